wb_write_arbiter: RTL

Write-back arbiter directly upstream of the register file's single write port. Merges two producers onto one registered write port: the in-order pipeline write-back (`pipe_*`, priority) and a long-latency unit (loads or multiply/divide, `lu_*`) buffered in a small FIFO. It also reports pending-write hazards to the issue stage.

---
 rtl/strontium_wb_pkg.sv | 12 +
 rtl/wb_fifo.sv | 66 ++++++
 rtl/wb_write_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/strontium_wb_pkg.sv
// Shared types and widths for the register-file write-back path.
package strontium_wb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] waddr;
      logic [XLEN-1:0]       wdata;
   } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests; also exposes per-entry valid/address
// so the top level can flag pending writes to the issue stage.
module wb_fifo
   import strontium_wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                push_i,
   input  wb_req_t                             push_data_i,
   input  logic                                pop_i,
   output wb_req_t                             head_o,
   output logic                                full_o,
   output logic                                empty_o,
   output logic [DEPTH-1:0]                    entry_valid_o,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0]    entry_addr_o
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra MSB so full and empty are distinguishable.
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count;
   logic [AW-1:0] slot_off;
   wb_req_t       mem_q [DEPTH];

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
   assign count   = wr_ptr_q - rd_ptr_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(push_i && !full_o);
      rd_ptr_d = rd_ptr_q + (AW+1)'(pop_i && !empty_o);
   end

   always_comb begin
      slot_off      = '0;
      entry_valid_o = '0;
      entry_addr_o  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot_off         = AW'(i) - rd_ptr_q[AW-1:0];
         entry_valid_o[i] = ({1'b0, slot_off} < count);
         entry_addr_o[i]  = mem_q[i].waddr;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !full_o) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
   end

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges pipeline write-back (priority) and buffered long-latency writes onto one
// registered register-file write port. Optional starvation guard: WB_STARVE_GUARD_EN.
module wb_write_arbiter
   import strontium_wb_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4
`ifdef WB_STARVE_GUARD_EN
   ,
   parameter int STARVE_LIMIT = 8
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pipe_valid,
   output logic                  pipe_ready,
   input  logic [REG_ADDR_W-1:0] pipe_waddr,
   input  logic [XLEN-1:0]       pipe_wdata,
   input  logic                  lu_valid,
   output logic                  lu_ready,
   input  logic [REG_ADDR_W-1:0] lu_waddr,
   input  logic [XLEN-1:0]       lu_wdata,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [XLEN-1:0]       rf_wdata,
   input  logic [REG_ADDR_W-1:0] q_addr1,
   input  logic [REG_ADDR_W-1:0] q_addr2,
   output logic                  q_busy1,
   output logic                  q_busy2
);

   wb_req_t                              pipe_req, lu_req, head;
   wb_req_t                              rf_req_q, rf_req_d;
   logic                                 rf_we_q, rf_we_d;
   logic                                 fifo_full, fifo_empty;
   logic                                 pipe_win, lu_push, fifo_pop;
   logic [FIFO_DEPTH-1:0]                ent_valid;
   logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] ent_addr;
   logic                                 hit1, hit2;

   assign pipe_req = '{waddr: pipe_waddr, wdata: pipe_wdata};
   assign lu_req   = '{waddr: lu_waddr, wdata: lu_wdata};

   // Writes to x0 are accepted and dropped on both sources.
   assign pipe_win = pipe_valid && pipe_ready && (pipe_waddr != '0);
   assign lu_ready = !fifo_full;
   assign lu_push  = lu_valid && !fifo_full && (lu_waddr != '0);
   assign fifo_pop = !fifo_empty && !pipe_win;

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk           (clk),
      .reset         (reset),
      .push_i        (lu_push),
      .push_data_i   (lu_req),
      .pop_i         (fifo_pop),
      .head_o        (head),
      .full_o        (fifo_full),
      .empty_o       (fifo_empty),
      .entry_valid_o (ent_valid),
      .entry_addr_o  (ent_addr)
   );

   always_comb begin
      rf_we_d  = pipe_win || fifo_pop;
      rf_req_d = rf_req_q;
      if (pipe_win) begin
         rf_req_d = pipe_req;
      end else if (fifo_pop) begin
         rf_req_d = head;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rf_we_q  <= 1'b0;
         rf_req_q <= '0;
      end else begin
         rf_we_q  <= rf_we_d;
         rf_req_q <= rf_req_d;
      end
   end

   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_req_q.waddr;
   assign rf_wdata = rf_req_q.wdata;

   // Pending = queued in the FIFO or sitting in the output register this cycle.
   always_comb begin
      hit1 = rf_we_q && (rf_req_q.waddr == q_addr1);
      hit2 = rf_we_q && (rf_req_q.waddr == q_addr2);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (ent_valid[i] && (ent_addr[i] == q_addr1)) hit1 = 1'b1;
         if (ent_valid[i] && (ent_addr[i] == q_addr2)) hit2 = 1'b1;
      end
   end

   assign q_busy1 = hit1 && (q_addr1 != '0);
   assign q_busy2 = hit2 && (q_addr2 != '0);

`ifdef WB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

   // Throttling the pipe for one cycle guarantees the head dequeues and clears the count.
   assign pipe_ready = (starve_cnt_q != CNT_W'(STARVE_LIMIT));

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (fifo_pop) begin
         starve_cnt_d = '0;
      end else if (!fifo_empty) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`else
   assign pipe_ready = 1'b1;
`endif

endmodule
